// File: rtl/mccpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, ALU codes, mux selects,
// opcode/funct values and the decoded-instruction flag bundle.
package mccpu_ctrl_pkg;

    localparam logic [2:0] StIf   = 3'd0;
    localparam logic [2:0] StId   = 3'd1;
    localparam logic [2:0] StExe  = 3'd2;
    localparam logic [2:0] StMem  = 3'd3;
    localparam logic [2:0] StWb   = 3'd4;
    localparam logic [2:0] StTrap = 3'd5;

    localparam logic [3:0] AluNop  = 4'd0;
    localparam logic [3:0] AluAdd  = 4'd1;
    localparam logic [3:0] AluSub  = 4'd2;
    localparam logic [3:0] AluAnd  = 4'd3;
    localparam logic [3:0] AluOr   = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluNor  = 4'd8;
    localparam logic [3:0] AluLui  = 4'd9;
    localparam logic [3:0] AluSrl  = 4'd10;

    localparam logic [2:0] PcAlu    = 3'd0;
    localparam logic [2:0] PcAluOut = 3'd1;
    localparam logic [2:0] PcJump   = 3'd2;
    localparam logic [2:0] PcRs     = 3'd3;
    localparam logic [2:0] PcExc    = 3'd4;

    localparam logic [1:0] GprRd = 2'd0;
    localparam logic [1:0] GprRt = 2'd1;
    localparam logic [1:0] GprRa = 2'd2;

    localparam logic [1:0] WdAlu = 2'd0;
    localparam logic [1:0] WdMem = 2'd1;
    localparam logic [1:0] WdPc  = 2'd2;

    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcARs    = 2'd1;
    localparam logic [1:0] SrcAShamt = 2'd2;

    localparam logic [1:0] SrcBRt   = 2'd0;
    localparam logic [1:0] SrcBFour = 2'd1;
    localparam logic [1:0] SrcBImm  = 2'd2;
    localparam logic [1:0] SrcBBr   = 2'd3;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    typedef struct packed {
        logic add;
        logic addu;
        logic sub;
        logic subu;
        logic r_and;
        logic r_or;
        logic r_nor;
        logic slt;
        logic sltu;
        logic sll;
        logic srl;
        logic sllv;
        logic srlv;
        logic jr;
        logic jalr;
        logic addi;
        logic andi;
        logic ori;
        logic slti;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
    } instr_t;

endpackage

// File: rtl/mccpu_decode.sv
// Combinational instruction decoder: one flag per supported instruction, plus valid
// when any flag is set.
module mccpu_decode
    import mccpu_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output instr_t     instr_o,
    output logic       valid_o
);

    logic rtype;

    always_comb begin
        rtype         = (op_i == OpRtype);
        instr_o       = '0;
        instr_o.add   = rtype && (funct_i == FnAdd);
        instr_o.addu  = rtype && (funct_i == FnAddu);
        instr_o.sub   = rtype && (funct_i == FnSub);
        instr_o.subu  = rtype && (funct_i == FnSubu);
        instr_o.r_and = rtype && (funct_i == FnAnd);
        instr_o.r_or  = rtype && (funct_i == FnOr);
        instr_o.r_nor = rtype && (funct_i == FnNor);
        instr_o.slt   = rtype && (funct_i == FnSlt);
        instr_o.sltu  = rtype && (funct_i == FnSltu);
        instr_o.sll   = rtype && (funct_i == FnSll);
        instr_o.srl   = rtype && (funct_i == FnSrl);
        instr_o.sllv  = rtype && (funct_i == FnSllv);
        instr_o.srlv  = rtype && (funct_i == FnSrlv);
        instr_o.jr    = rtype && (funct_i == FnJr);
        instr_o.jalr  = rtype && (funct_i == FnJalr);
        instr_o.addi  = (op_i == OpAddi);
        instr_o.andi  = (op_i == OpAndi);
        instr_o.ori   = (op_i == OpOri);
        instr_o.slti  = (op_i == OpSlti);
        instr_o.lui   = (op_i == OpLui);
        instr_o.lw    = (op_i == OpLw);
        instr_o.sw    = (op_i == OpSw);
        instr_o.beq   = (op_i == OpBeq);
        instr_o.bne   = (op_i == OpBne);
        instr_o.j     = (op_i == OpJ);
        instr_o.jal   = (op_i == OpJal);
        valid_o       = |instr_o;
    end

endmodule

// File: rtl/mccpu_ctrl_hs.sv
// Multicycle MIPS-subset control FSM with variable-latency memory handshake and an
// illegal-instruction trap state.
module mccpu_ctrl_hs
    import mccpu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4,
    parameter bit          MEM_HS  = 1'b1,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               zero_i,
    input  logic [5:0]         op_i,
    input  logic [5:0]         funct_i,
    input  logic               mem_ready_i,
    output logic               reg_write_o,
    output logic               mem_write_o,
    output logic               mem_read_o,
    output logic               pc_write_o,
    output logic               ir_write_o,
    output logic               epc_write_o,
    output logic               ext_op_o,
    output logic [1:0]         alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [2:0]         pc_source_o,
    output logic [1:0]         gpr_sel_o,
    output logic [1:0]         wd_sel_o,
    output logic               i_or_d_o,
    output logic               illegal_o,
    output logic [2:0]         state_o
);

    logic [2:0] state_q, state_d;
    logic       illegal_q;
    instr_t     instr;
    logic       valid;
    logic       ready;
    logic       is_imm;
    logic [3:0] exe_alu_op;
    logic [3:0] alu_code;

    mccpu_decode u_decode (
        .op_i    (op_i),
        .funct_i (funct_i),
        .instr_o (instr),
        .valid_o (valid)
    );

    assign ready  = MEM_HS ? mem_ready_i : 1'b1;
    assign is_imm = instr.addi | instr.andi | instr.ori | instr.slti | instr.lui;

    always_comb begin
        exe_alu_op = AluNop;
        if (instr.add || instr.addu || instr.addi || instr.lw || instr.sw) begin
            exe_alu_op = AluAdd;
        end else if (instr.sub || instr.subu || instr.beq || instr.bne) begin
            exe_alu_op = AluSub;
        end else if (instr.r_and || instr.andi) begin
            exe_alu_op = AluAnd;
        end else if (instr.r_or || instr.ori) begin
            exe_alu_op = AluOr;
        end else if (instr.r_nor) begin
            exe_alu_op = AluNor;
        end else if (instr.slt || instr.slti) begin
            exe_alu_op = AluSlt;
        end else if (instr.sltu) begin
            exe_alu_op = AluSltu;
        end else if (instr.sll || instr.sllv) begin
            exe_alu_op = AluSll;
        end else if (instr.srl || instr.srlv) begin
            exe_alu_op = AluSrl;
        end else if (instr.lui) begin
            exe_alu_op = AluLui;
        end
    end

    // While rst is high the case is skipped, so strobes are 0 and selects sit at defaults.
    always_comb begin
        state_d     = StIf;
        reg_write_o = 1'b0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        pc_write_o  = 1'b0;
        ir_write_o  = 1'b0;
        epc_write_o = 1'b0;
        ext_op_o    = 1'b1;
        alu_src_a_o = SrcARs;
        alu_src_b_o = SrcBRt;
        alu_code    = AluAdd;
        pc_source_o = PcAlu;
        gpr_sel_o   = GprRd;
        wd_sel_o    = WdAlu;
        i_or_d_o    = 1'b0;
        if (!rst) begin
            case (state_q)
                StIf: begin
                    mem_read_o  = 1'b1;
                    alu_src_a_o = SrcAPc;
                    alu_src_b_o = SrcBFour;
                    if (ready) begin
                        pc_write_o = 1'b1;
                        ir_write_o = 1'b1;
                        state_d    = StId;
                    end else begin
                        state_d = StIf;
                    end
                end
                StId: begin
                    if (instr.j || instr.jal) begin
                        pc_source_o = PcJump;
                        pc_write_o  = 1'b1;
                        if (instr.jal) begin
                            reg_write_o = 1'b1;
                            gpr_sel_o   = GprRa;
                            wd_sel_o    = WdPc;
                        end
                    end else if (instr.jr || instr.jalr) begin
                        pc_source_o = PcRs;
                        pc_write_o  = 1'b1;
                        if (instr.jalr) begin
                            reg_write_o = 1'b1;
                            gpr_sel_o   = GprRd;
                            wd_sel_o    = WdPc;
                        end
                    end else if (!valid) begin
                        state_d = TRAP_EN ? StTrap : StIf;
                    end else begin
                        alu_src_a_o = SrcAPc;
                        alu_src_b_o = SrcBBr;
                        state_d     = StExe;
                    end
                end
                StExe: begin
                    alu_code = exe_alu_op;
                    if (instr.beq || instr.bne) begin
                        pc_source_o = PcAluOut;
                        pc_write_o  = instr.beq ? zero_i : ~zero_i;
                    end else if (instr.lw || instr.sw) begin
                        alu_src_b_o = SrcBImm;
                        state_d     = StMem;
                    end else begin
                        if (instr.sll || instr.srl) begin
                            alu_src_a_o = SrcAShamt;
                        end
                        if (is_imm) begin
                            alu_src_b_o = SrcBImm;
                            ext_op_o    = ~(instr.andi | instr.ori);
                        end
                        state_d = StWb;
                    end
                end
                StMem: begin
                    i_or_d_o    = 1'b1;
                    mem_read_o  = instr.lw;
                    mem_write_o = instr.sw;
                    if (ready) begin
                        state_d = instr.lw ? StWb : StIf;
                    end else begin
                        state_d = StMem;
                    end
                end
                StWb: begin
                    reg_write_o = 1'b1;
                    if (instr.lw) begin
                        wd_sel_o = WdMem;
                    end
                    if (is_imm || instr.lw) begin
                        gpr_sel_o = GprRt;
                    end
                end
                StTrap: begin
                    epc_write_o = 1'b1;
                    pc_source_o = PcExc;
                    pc_write_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIf;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_d == StTrap);
        end
    end

    assign alu_op_o  = ALUOP_W'(alu_code);
    assign illegal_o = illegal_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mccpu_ctrl_hs.sv
// Randomized bench for mccpu_ctrl_hs: one instance with handshake and trap enabled, one
// with both disabled, each compared cycle by cycle against an instruction-level model.
module tb_mccpu_ctrl_hs;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       pc_write;
        logic       ir_write;
        logic       epc_write;
        logic       ext_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] aop;
        logic [2:0] pcs;
        logic [1:0] gpr;
        logic [1:0] wd;
        logic       iod;
        logic       ill;
    } exp_t;

    localparam int KAlu = 0, KJump = 1, KBranch = 2, KLoad = 3, KStore = 4, KBad = 5;
    localparam int PIf = 0, PId = 1, PExe = 2, PMem = 3, PWb = 4, PTrap = 5;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         kind;
        logic [3:0] aop;
        bit         imm, zext, shamt, itype, link, rjump, bne;
    } ins_t;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] op_v[2];
    logic [5:0] funct_v[2];
    logic       zero_v[2];
    logic       mr_v[2];

    logic       rw_w[2], mw_w[2], mr_w[2], pw_w[2], iw_w[2], ew_w[2], ext_w[2], iod_w[2], ill_w[2];
    logic [1:0] sa_w[2], sb_w[2], gpr_w[2], wd_w[2];
    logic [3:0] aop_w[2];
    logic [2:0] pcs_w[2], st_w[2];
    exp_t       out_v[2];

    int n_chk  = 0;
    int n_pass = 0;
    ins_t tbl[$];

    always #5 clk = ~clk;

    mccpu_ctrl_hs u_dut_hs (
        .clk(clk), .rst(rst), .zero_i(zero_v[0]), .op_i(op_v[0]), .funct_i(funct_v[0]),
        .mem_ready_i(mr_v[0]), .reg_write_o(rw_w[0]), .mem_write_o(mw_w[0]),
        .mem_read_o(mr_w[0]), .pc_write_o(pw_w[0]), .ir_write_o(iw_w[0]),
        .epc_write_o(ew_w[0]), .ext_op_o(ext_w[0]), .alu_src_a_o(sa_w[0]),
        .alu_src_b_o(sb_w[0]), .alu_op_o(aop_w[0]), .pc_source_o(pcs_w[0]),
        .gpr_sel_o(gpr_w[0]), .wd_sel_o(wd_w[0]), .i_or_d_o(iod_w[0]),
        .illegal_o(ill_w[0]), .state_o(st_w[0])
    );

    mccpu_ctrl_hs #(.ALUOP_W(4), .MEM_HS(1'b0), .TRAP_EN(1'b0)) u_dut_plain (
        .clk(clk), .rst(rst), .zero_i(zero_v[1]), .op_i(op_v[1]), .funct_i(funct_v[1]),
        .mem_ready_i(mr_v[1]), .reg_write_o(rw_w[1]), .mem_write_o(mw_w[1]),
        .mem_read_o(mr_w[1]), .pc_write_o(pw_w[1]), .ir_write_o(iw_w[1]),
        .epc_write_o(ew_w[1]), .ext_op_o(ext_w[1]), .alu_src_a_o(sa_w[1]),
        .alu_src_b_o(sb_w[1]), .alu_op_o(aop_w[1]), .pc_source_o(pcs_w[1]),
        .gpr_sel_o(gpr_w[1]), .wd_sel_o(wd_w[1]), .i_or_d_o(iod_w[1]),
        .illegal_o(ill_w[1]), .state_o(st_w[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign out_v[g] = {rw_w[g], mw_w[g], mr_w[g], pw_w[g], iw_w[g], ew_w[g], ext_w[g],
                           sa_w[g], sb_w[g], aop_w[g], pcs_w[g], gpr_w[g], wd_w[g],
                           iod_w[g], ill_w[g]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic ins_t mk(logic [5:0] op, logic [5:0] funct, int kind, logic [3:0] aop,
                                bit imm = 0, bit zext = 0, bit shamt = 0, bit itype = 0,
                                bit link = 0, bit rjump = 0, bit bne = 0);
        ins_t t;
        t.op = op; t.funct = funct; t.kind = kind; t.aop = aop;
        t.imm = imm; t.zext = zext; t.shamt = shamt; t.itype = itype;
        t.link = link; t.rjump = rjump; t.bne = bne;
        return t;
    endfunction

    function automatic exp_t idle_outs();
        exp_t e = '0;
        e.ext_op = 1'b1;
        e.src_a  = 2'd1;
        e.aop    = 4'd1;
        return e;
    endfunction

    // Expected outputs for one cycle of an instruction, from the per-state rules.
    function automatic exp_t expect_outs(ins_t in, int ph, bit r, bit z);
        exp_t e = idle_outs();
        case (ph)
            PIf: begin
                e.mem_read = 1'b1; e.src_a = 2'd0; e.src_b = 2'd1;
                e.pc_write = r; e.ir_write = r;
            end
            PId: begin
                if (in.kind == KJump) begin
                    e.pc_write = 1'b1;
                    e.pcs = in.rjump ? 3'd3 : 3'd2;
                    if (in.link) begin
                        e.reg_write = 1'b1; e.wd = 2'd2;
                        e.gpr = in.rjump ? 2'd0 : 2'd2;
                    end
                end else if (in.kind != KBad) begin
                    e.src_a = 2'd0; e.src_b = 2'd3;
                end
            end
            PExe: begin
                e.aop = in.aop;
                if (in.kind == KBranch) begin
                    e.pcs = 3'd1; e.pc_write = in.bne ? !z : z;
                end else if (in.kind == KLoad || in.kind == KStore) begin
                    e.src_b = 2'd2;
                end else begin
                    if (in.shamt) e.src_a = 2'd2;
                    if (in.imm) begin e.src_b = 2'd2; e.ext_op = !in.zext; end
                end
            end
            PMem: begin
                e.iod = 1'b1;
                e.mem_read  = (in.kind == KLoad);
                e.mem_write = (in.kind == KStore);
            end
            PWb: begin
                e.reg_write = 1'b1;
                if (in.kind == KLoad) e.wd = 2'd1;
                if (in.itype) e.gpr = 2'd1;
            end
            PTrap: begin
                e.epc_write = 1'b1; e.pcs = 3'd4; e.pc_write = 1'b1; e.ill = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int base_latency(int kind, bit trap);
        case (kind)
            KJump:   return 2;
            KBranch: return 3;
            KLoad:   return 5;
            KStore:  return 4;
            KBad:    return trap ? 3 : 2;
            default: return 4;
        endcase
    endfunction

    // Starts and ends at posedge+1 with the DUT in IF.
    task automatic run_ins(input int d, input ins_t in, input int if_w, input int mem_w,
                           input bit z);
        int ph[$];
        bit hs = (d == 0);
        int cycles = 0;
        int lat;
        op_v[d] = in.op;
        funct_v[d] = (in.op != 6'h00) ? 6'($urandom) : in.funct;
        zero_v[d] = z;
        ph.push_back(PIf);
        ph.push_back(PId);
        case (in.kind)
            KAlu:    begin ph.push_back(PExe); ph.push_back(PWb); end
            KBranch: ph.push_back(PExe);
            KLoad:   begin ph.push_back(PExe); ph.push_back(PMem); ph.push_back(PWb); end
            KStore:  begin ph.push_back(PExe); ph.push_back(PMem); end
            KBad:    if (hs) ph.push_back(PTrap);
            default: ;
        endcase
        foreach (ph[k]) begin
            int waits = 0;
            bit mem_ph = (ph[k] == PIf) || (ph[k] == PMem);
            if (hs && ph[k] == PIf) waits = if_w;
            if (hs && ph[k] == PMem) waits = mem_w;
            for (int w = 0; w <= waits; w++) begin
                bit r;
                if (hs && mem_ph) mr_v[d] = (w == waits);
                else mr_v[d] = 1'($urandom);
                r = hs ? mr_v[d] : 1'b1;
                @(negedge clk);
                check_eq($sformatf("d%0d op%02h st ph%0d w%0d", d, in.op, ph[k], w),
                         32'(st_w[d]), 32'(ph[k]));
                check_eq($sformatf("d%0d op%02h/%02h outs ph%0d w%0d", d, in.op, in.funct,
                                   ph[k], w),
                         32'(out_v[d]), 32'(expect_outs(in, ph[k], r, z)));
                cycles++;
                @(posedge clk);
                #1;
            end
        end
        lat = base_latency(in.kind, hs);
        if (hs) lat += if_w + ((in.kind == KLoad || in.kind == KStore) ? mem_w : 0);
        check_eq($sformatf("d%0d op%02h latency", d, in.op), 32'(cycles), 32'(lat));
        check_eq($sformatf("d%0d op%02h back to IF", d, in.op), 32'(st_w[d]), 32'd0);
    endtask

    task automatic reset_and_check();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mr_v[0] = 1'b1;
        mr_v[1] = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d reset state", d), 32'(st_w[d]), 32'd0);
            check_eq($sformatf("d%0d reset outs", d), 32'(out_v[d]), 32'(idle_outs()));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            op_v[d] = '0; funct_v[d] = '0; zero_v[d] = 1'b0; mr_v[d] = 1'b0;
        end
        tbl.push_back(mk(6'h00, 6'h20, KAlu, 4'd1));
        tbl.push_back(mk(6'h00, 6'h21, KAlu, 4'd1));
        tbl.push_back(mk(6'h00, 6'h22, KAlu, 4'd2));
        tbl.push_back(mk(6'h00, 6'h23, KAlu, 4'd2));
        tbl.push_back(mk(6'h00, 6'h24, KAlu, 4'd3));
        tbl.push_back(mk(6'h00, 6'h25, KAlu, 4'd4));
        tbl.push_back(mk(6'h00, 6'h27, KAlu, 4'd8));
        tbl.push_back(mk(6'h00, 6'h2A, KAlu, 4'd5));
        tbl.push_back(mk(6'h00, 6'h2B, KAlu, 4'd6));
        tbl.push_back(mk(6'h00, 6'h00, KAlu, 4'd7, 0, 0, 1));
        tbl.push_back(mk(6'h00, 6'h02, KAlu, 4'd10, 0, 0, 1));
        tbl.push_back(mk(6'h00, 6'h04, KAlu, 4'd7));
        tbl.push_back(mk(6'h00, 6'h06, KAlu, 4'd10));
        tbl.push_back(mk(6'h00, 6'h08, KJump, 4'd0, 0, 0, 0, 0, 0, 1));     // jr
        tbl.push_back(mk(6'h00, 6'h09, KJump, 4'd0, 0, 0, 0, 0, 1, 1));     // jalr
        tbl.push_back(mk(6'h08, 6'h00, KAlu, 4'd1, 1, 0, 0, 1));            // addi
        tbl.push_back(mk(6'h0C, 6'h00, KAlu, 4'd3, 1, 1, 0, 1));            // andi
        tbl.push_back(mk(6'h0D, 6'h00, KAlu, 4'd4, 1, 1, 0, 1));            // ori
        tbl.push_back(mk(6'h0A, 6'h00, KAlu, 4'd5, 1, 0, 0, 1));            // slti
        tbl.push_back(mk(6'h0F, 6'h00, KAlu, 4'd9, 1, 0, 0, 1));            // lui
        tbl.push_back(mk(6'h23, 6'h00, KLoad, 4'd1, 0, 0, 0, 1));           // lw
        tbl.push_back(mk(6'h2B, 6'h00, KStore, 4'd1));                      // sw
        tbl.push_back(mk(6'h04, 6'h00, KBranch, 4'd2));                     // beq
        tbl.push_back(mk(6'h05, 6'h00, KBranch, 4'd2, 0, 0, 0, 0, 0, 0, 1)); // bne
        tbl.push_back(mk(6'h02, 6'h00, KJump, 4'd0));                       // j
        tbl.push_back(mk(6'h03, 6'h00, KJump, 4'd0, 0, 0, 0, 0, 1));        // jal
        tbl.push_back(mk(6'h3F, 6'h00, KBad, 4'd0));
        tbl.push_back(mk(6'h00, 6'h01, KBad, 4'd0));
        tbl.push_back(mk(6'h00, 6'h3F, KBad, 4'd0));
        tbl.push_back(mk(6'h10, 6'h00, KBad, 4'd0));

        #12;
        reset_and_check();
        // Handshake/trap instance: directed cases, then random.
        run_ins(0, tbl[0], 0, 0, 1'b0);    // add
        run_ins(0, tbl[20], 3, 2, 1'b0);   // lw with waits: 10 cycles
        run_ins(0, tbl[22], 0, 0, 1'b1);   // beq taken
        run_ins(0, tbl[22], 0, 0, 1'b0);   // beq not taken
        run_ins(0, tbl[23], 0, 0, 1'b1);   // bne
        run_ins(0, tbl[23], 0, 0, 1'b0);
        run_ins(0, tbl[14], 0, 0, 1'b0);   // jalr
        run_ins(0, tbl[26], 0, 0, 1'b0);   // op 0x3F traps
        run_ins(0, tbl[21], 1, 2, 1'b0);   // sw with waits
        for (int i = 0; i < 150; i++) begin
            run_ins(0, tbl[$urandom_range(0, tbl.size() - 1)], $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom));
        end

        // sw stalled in MEM, then rst mid-cycle.
        op_v[0] = 6'h2B;
        mr_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mr_v[0] = 1'b0;
        @(negedge clk);
        check_eq("sw wait state", 32'(st_w[0]), 32'd3);
        check_eq("sw wait mem_write", 32'(mw_w[0]), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst mid-wait mem_write", 32'(mw_w[0]), 32'd0);
        check_eq("rst mid-wait state", 32'(st_w[0]), 32'd0);
        check_eq("rst mid-wait outs", 32'(out_v[0]), 32'(idle_outs()));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_ins(0, tbl[0], 0, 0, 1'b0);

        // Plain instance: mem_ready ignored, undecoded instructions act as NOPs.
        reset_and_check();
        run_ins(1, tbl[26], 0, 0, 1'b0);
        run_ins(1, tbl[27], 0, 0, 1'b0);
        run_ins(1, tbl[20], 0, 0, 1'b0);
        run_ins(1, tbl[0], 0, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            run_ins(1, tbl[$urandom_range(0, tbl.size() - 1)], 0, 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mccpu_ctrl_hs.md
# mccpu_ctrl_hs

Multicycle MIPS-subset control unit with a variable-latency memory handshake and an illegal-instruction trap. It sits beside the multicycle datapath and drives every datapath enable and mux select from a six-state FSM. Generics allow the memory handshake and the trap to be disabled. The ALU operation field width is also configurable, so the block can be reused by later datapath generations.

## Interface
- ALUOP_W, 4: width of alu_op; must be ≥ 4.
- MEM_HS, 1: 1 = wait for mem_ready in IF and MEM; 0 = memory treated as always ready, mem_ready ignored.
- TRAP_EN, 1: 1 = undecoded opcode/funct enters TRAP; 0 = undecoded instruction is a NOP (ID→IF).
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- zero in 1: ALU zero flag.
- op in 6: instruction opcode from IR.
- funct in 6: instruction funct from IR.
- mem_ready in 1: memory completes the current read/write this cycle.
- reg_write, mem_write, mem_read, pc_write, ir_write, epc_write out 1 each: write/access strobes.
- ext_op out 1: 1 = sign extend, 0 = zero extend.
- alu_src_a out 2: 0 = PC, 1 = rs data, 2 = shamt.
- alu_src_b out 2: 0 = rt data, 1 = const 4, 2 = ext imm, 3 = branch offset.
- alu_op out ALUOP_W: ALU operation code.
- pc_source out 3: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs, 4 = exception vector.
- gpr_sel out 2: 0 = rd, 1 = rt, 2 = r31.
- wd_sel out 2: 0 = ALU, 1 = MEM, 2 = PC.
- i_or_d out 1: 0 = instruction address, 1 = data address.
- illegal out 1: registered; high for the single cycle spent in TRAP.
- state_o out 3: current state, for debug and for the bench.

## Operation
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl, sllv, srlv, jr, jalr.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Outputs are combinational from state, op, funct, zero and mem_ready.
- Output defaults, apart from any state-specific override: all strobes 0, ext_op=1, alu_src_a=1, alu_src_b=0, alu_op=ADD, pc_source=0, gpr_sel=0, wd_sel=0, i_or_d=0.
- IF:
  - Drives mem_read=1, alu_src_a=0, alu_src_b=1.
  - When mem_ready=1 (or MEM_HS=0), asserts pc_write=ir_write=1 and moves to ID; otherwise holds IF.
- ID:
  - j: pc_source=2, pc_write=1 → IF.
  - jal: same as j, plus reg_write=1, gpr_sel=2, wd_sel=2 → IF.
  - jr: pc_source=3, pc_write=1 → IF.
  - jalr: same as jr, plus reg_write=1, gpr_sel=0 (link register is rd), wd_sel=2 → IF.
  - Undecoded instruction: → TRAP if TRAP_EN=1, else → IF.
  - Any other instruction: alu_src_a=0, alu_src_b=3 (branch target precompute) → EXE.
- EXE:
  - alu_op is decoded from the instruction class.
  - beq/bne: pc_source=1; pc_write=zero for beq, ~zero for bne → IF.
  - lw/sw: alu_src_b=2 → MEM.
  - sll/srl: alu_src_a=2 → WB.
  - Immediate arithmetic/logic: alu_src_b=2; ext_op=0 for andi and ori → WB.
  - Other R-type → WB.
- MEM:
  - i_or_d=1.
  - lw: mem_read=1.
  - sw: mem_write=1, held until ready.
  - On ready: lw → WB, sw → IF. Otherwise hold MEM.
- WB:
  - reg_write=1.
  - lw: wd_sel=1.
  - I-type: gpr_sel=1.
  - → IF.
- TRAP: epc_write=1, pc_source=4, pc_write=1, illegal=1 → IF.
- alu_op codes, zero-extended to ALUOP_W: NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, NOR 8, LUI 9, SRL 10, SLL 7.
- addu uses ADD, subu uses SUB, slti uses SLT, sllv uses SLL, srlv uses SRL.

## Timing
- Reset:
  - State becomes IF immediately.
  - While rst=1, every strobe is forced to 0. Selects hold their defaults.
  - illegal=0, state_o=0.
- After reset release, the first rising clk edge evaluates IF normally.
- Latency with mem_ready tied to 1:
  - j/jal/jr/jalr: 2 cycles.
  - beq/bne: 3 cycles.
  - R-type/I-type ALU: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with mem_ready=0 in IF or MEM adds exactly one cycle.
- mem_read/mem_write stay asserted and stable throughout a wait.
- A mem_ready pulse outside IF and MEM is ignored.
- rst asserted mid-wait abandons the access; mem_write drops in the same cycle.
- State encoding: IF 0, ID 1, EXE 2, MEM 3, WB 4, TRAP 5.
- Unused codes 6 and 7 → IF with all strobes 0.

## Structure
- Package mccpu_ctrl_pkg holds:
  - state encodings;
  - alu_op codes;
  - pc_source, gpr_sel, wd_sel, alu_src_a, alu_src_b constants.
- Sub-module mccpu_decode, purely combinational: maps op/funct to one-hot instruction flags plus a `valid` flag.
- mccpu_ctrl_hs contains the state register and the output/next-state logic.

## Test plan
- add (op=0, funct=0x20), mem_ready=1: state sequence 0,1,2,4,0; alu_op=1 in EXE; reg_write=1, gpr_sel=0 only in WB.
- lw (op=0x23) with mem_ready low for 3 IF cycles and 2 MEM cycles: total 10 cycles; wd_sel=1 and gpr_sel=1 in WB; no strobe pulses while waiting.
- beq (op=0x04) with zero=1, then with zero=0: pc_write=1, pc_source=1 in EXE only in the zero=1 case; bne gives the inverse.
- jalr (funct=0x09): in ID, pc_source=3, reg_write=1, gpr_sel=0, wd_sel=2; back to IF after 2 cycles.
- op=0x3F:
  - TRAP_EN=1: ID→TRAP(5) with illegal=1, epc_write=1, pc_source=4 → IF.
  - TRAP_EN=0: ID→IF with no strobes.
- sw waiting in MEM with mem_write=1, rst pulsed: mem_write=0 in the same cycle; state_o=0; after release the next fetch starts cleanly.
